// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command driver: opcodes, widths and
// the driver's sequencing states.
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_RES_W  = ALU_DATA_W + 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MOD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_LAND = 3'b100;
  localparam logic [2:0] OP_LOR  = 3'b101;
  localparam logic [2:0] OP_LNOT = 3'b110;
  localparam logic [2:0] OP_EQ   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } alu_drv_state_t;

endpackage

// File: rtl/alu_cmd_driver_if.sv
// Signal bundle between the command source, the driver, the ALU and the
// response sink.
interface alu_cmd_driver_if #(
  parameter int DATA_W = 32
);

  // cmd_* and rsp_* are valid/ready: a transfer happens on a rising edge where
  // both are 1; the source keeps valid and its payload stable until then.
  // alu_en/alu_ack: operands are held while en is high, ack qualifies result.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;

  logic              alu_en;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_ack;
  logic [DATA_W:0]   alu_result;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W:0]   rsp_data;
  logic              rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_ack, alu_result, rsp_ready,
    output cmd_ready, alu_en, alu_op, alu_a, alu_b, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_ack, alu_result, rsp_ready,
    input  cmd_ready, alu_en, alu_op, alu_a, alu_b, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/alu_drv_timer.sv
// Clearable saturating counter used to bound the wait for the ALU acknowledge.
module alu_drv_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_W'(TIMEOUT))) begin
      count <= count + CNT_W'(1);
    end
  end

  // Flags the increment that brings the count up to TIMEOUT.
  assign done = inc && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/alu_cmd_driver.sv
// Sequences one command at a time onto the ALU en/ack port and returns the
// captured result (or an error for mod-by-zero / missing ack) downstream.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_cmd_driver_if.master  bus,
  output alu_drv_state_t    state_dbg
);

  alu_drv_state_t state, state_nxt;
  logic           accept;
  logic           div0;
  logic           tmr_clr;
  logic           tmr_inc;
  logic           tmr_done;

  assign accept = (state == ST_IDLE) && bus.cmd_valid;
  assign div0   = (bus.cmd_op == OP_MOD) && (bus.cmd_b == {DATA_W{1'b0}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_clr   = 1'b0;
    tmr_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          state_nxt = div0 ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmr_clr   = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // An ack in the timeout cycle still wins.
        if (bus.alu_ack) begin
          state_nxt = ST_RESP;
        end else begin
          tmr_inc = 1'b1;
          if (tmr_done) begin
            state_nxt = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  alu_drv_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .inc   (tmr_inc),
    .done  (tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_op   <= 3'b000;
      bus.alu_a    <= {DATA_W{1'b0}};
      bus.alu_b    <= {DATA_W{1'b0}};
      bus.rsp_data <= {(DATA_W+1){1'b0}};
      bus.rsp_err  <= 1'b0;
    end else begin
      if (accept) begin
        bus.alu_op <= bus.cmd_op;
        bus.alu_a  <= bus.cmd_a;
        bus.alu_b  <= bus.cmd_b;
        if (div0) begin
          bus.rsp_data <= {(DATA_W+1){1'b0}};
          bus.rsp_err  <= 1'b1;
        end
      end
      if (state == ST_WAIT) begin
        if (bus.alu_ack) begin
          bus.rsp_data <= bus.alu_result;
          bus.rsp_err  <= 1'b0;
        end else if (tmr_done) begin
          bus.rsp_data <= {(DATA_W+1){1'b0}};
          bus.rsp_err  <= 1'b1;
        end
      end
    end
  end

  // Decoded from state so reset drops en/valid without waiting for a clock.
  assign bus.cmd_ready = (state == ST_IDLE);
  assign bus.alu_en    = (state == ST_ISSUE) || (state == ST_WAIT);
  assign bus.rsp_valid = (state == ST_RESP);
  assign state_dbg     = state;

endmodule
